rgb_cmp_searcher: RTL and testbench
===================================

# rgb_cmp_searcher

Binary-search initiator for the RGB magnitude-comparator flags. The block drives the comparator's `b` operand with successive guesses and reads back the three flags. It converges on the comparator's hidden `a` operand and reports the value, the probe count, and any flag inconsistency. It sits on the other side of the comparator: the comparator answers, this block asks.

## Interface

Parameters:
- `W`, default 2: operand width in bits. Legal range 1–8.
- `SETTLE`, default 0: extra wait cycles after each new guess before the flags are sampled.

Ports:
- `clk`, in, 1: single clock. Every state changes on its rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `start`, in, 1: start a search. Ignored unless the block is in IDLE or DONE or ERR.
- `r_le`, in, 1: comparator R flag, meaning a ≤ b.
- `g_ne`, in, 1: comparator G flag, meaning a ≠ b.
- `b_ge`, in, 1: comparator B flag, meaning a ≥ b.
- `guess`, out, W: value driven to the comparator `b` port.
- `busy`, out, 1: high while a search is in progress.
- `done`, out, 1: high in DONE. Stays high until the next `start` or reset.
- `found`, out, W: value found. Valid while `done` is high.
- `probes`, out, clog2(W+2): number of flag samples taken in the current or last search.
- `err`, out, 1: high in ERR. Stays high until the next `start` or reset.

## Operation

Flag decode, as `{r_le,g_ne,b_ge}`:
- 101 = EQ.
- 110 = HIGH: guess > a.
- 011 = LOW: guess < a.
- Any other code = ILLEGAL.

States: IDLE, WAIT, SAMPLE, DONE, ERR.

- **IDLE, or DONE/ERR with `start`=1** → WAIT.
  - Set `lo`=0 and `hi`=2^W−1.
  - Set `guess`=(lo+hi)>>1, using a W+1-bit sum. This gives 2^(W−1)−1.
  - Clear `probes`, `done` and `err`.
  - Load the settle counter with SETTLE.
- **WAIT**: decrement the settle counter. Go to SAMPLE once the counter reaches 0. With SETTLE=0, WAIT lasts exactly 1 cycle.
- **SAMPLE**: increment `probes`, then act on the decoded flags.
  - EQ → DONE, with `found`=`guess`.
  - HIGH:
    - If `guess`==`lo` → ERR. The range is exhausted; no underflow is allowed.
    - Otherwise set `hi`=`guess`−1, compute a new midpoint `guess`, and go to WAIT.
  - LOW:
    - If `guess`==`hi` → ERR. This also covers `guess`=2^W−1, so there is no wrap.
    - Otherwise set `lo`=`guess`+1, compute a new midpoint, and go to WAIT.
  - ILLEGAL → ERR.
- **DONE and ERR**: `guess` holds its last value.
- **`start` while busy**: ignored. The search does not restart.
- **Reset mid-search**: all state returns to the reset values on the next edge. No partial result survives.

## Timing

Reset values (rst_n=0 at an edge):
- State IDLE.
- `guess`=0, `found`=0, `probes`=0.
- `busy`=0, `done`=0, `err`=0.
- `lo`=0, `hi`=all-ones.

Per-probe latency:
- Each probe takes 1+SETTLE cycles in WAIT plus 1 cycle in SAMPLE.
- `guess` is registered. The flags are sampled at the SAMPLE edge, so the comparator may be purely combinational.
- Maximum probes for any a: W+1.
- Worst-case search latency: (W+1)·(2+SETTLE) cycles from the `start` edge to `done` rising.

Output timing:
- `busy` is high in WAIT and SAMPLE. It falls on the same edge that raises `done` or `err`.
- `done` and `err` are never high together.

## Structure

Shared package `rgb_cmp_pkg` holds:
- typedef `cmp_res_e` with values EQ, HIGH, LOW, ILLEGAL.
- function `decode_flags(r,g,b)` returning `cmp_res_e`.
- typedef `srch_state_e` for the five states.

One sub-module, `rgb_flag_decode`, is a combinational wrapper around `decode_flags`. It is reused by the monitor in the bench.

The bench instantiates the existing comparator with `a` tied to the secret and `b` driven by `guess`. The flags feed straight back.

## Test plan

- W=2, SETTLE=0, a=0..3 exhaustive, `start` pulse.
  - a=1 → `done` after 2 cycles, with `found`=1 and `probes`=1.
  - a=3 → `found`=3 with `probes`=3.
- W=4, SETTLE=2, a=15 → guesses 7, 11, 13, 14, 15, then `found`=15 with `probes`=5 and a total of 20 cycles.
- Flags forced to 000 in the first SAMPLE → `err`=1 and `busy`=0, and `guess` holds 1 (W=2).
- Flags forced permanently to LOW (011) with W=2 → guesses 1, 2, 3, then `err` at `guess`=3. `guess` must never wrap to 0.
- `rst_n` asserted in the second WAIT of a W=4 search → next cycle all outputs are at their reset values. A `start` afterwards completes normally.
- `start` held high through the whole search, then again after DONE → there is no restart mid-search. The re-search clears `done` at the `start` edge and finds the same value.

Source files
------------

// File: rtl/rgb_cmp_pkg.sv
// Shared types for the RGB comparator searcher: decoded comparator answers,
// the search FSM states and the flag decode function.
package rgb_cmp_pkg;

    typedef enum logic [1:0] {
        EQ      = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2,
        ILLEGAL = 2'd3
    } cmp_res_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SAMPLE = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } srch_state_e;

    // Flags arrive as {r_le, g_ne, b_ge}; only three codes are self-consistent.
    function automatic cmp_res_e decode_flags(input logic r, input logic g, input logic b);
        cmp_res_e res;
        case ({r, g, b})
            3'b101:  res = EQ;
            3'b110:  res = HIGH;
            3'b011:  res = LOW;
            default: res = ILLEGAL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rgb_flag_decode.sv
// Combinational wrapper around decode_flags so the same decode can be
// instantiated wherever comparator flags need interpreting.
module rgb_flag_decode
    import rgb_cmp_pkg::*;
(
    input  logic     r_le,
    input  logic     g_ne,
    input  logic     b_ge,
    output cmp_res_e res
);

    assign res = decode_flags(r_le, g_ne, b_ge);

endmodule

// File: rtl/rgb_cmp_searcher.sv
// Binary-search initiator: drives guesses into the RGB comparator's b port and
// converges on its hidden a operand, flagging any inconsistent answer.
module rgb_cmp_searcher
    import rgb_cmp_pkg::*;
#(
    parameter int W      = 2,
    parameter int SETTLE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      r_le,
    input  logic                      g_ne,
    input  logic                      b_ge,
    output logic [W-1:0]              guess,
    output logic                      busy,
    output logic                      done,
    output logic [W-1:0]              found,
    output logic [$clog2(W+2)-1:0]    probes,
    output logic                      err
);

    localparam int PW = $clog2(W + 2);
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);

    srch_state_e    state, state_next;
    logic [W-1:0]   lo, lo_next;
    logic [W-1:0]   hi, hi_next;
    logic [W-1:0]   guess_next;
    logic [W-1:0]   found_next;
    logic [PW-1:0]  probes_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [W-1:0]   guess_dec;
    logic [W-1:0]   guess_inc;
    cmp_res_e       res;

    // The W+1-bit sum keeps lo+hi from overflowing before the halving.
    function automatic logic [W-1:0] midpoint(input logic [W-1:0] l, input logic [W-1:0] h);
        logic [W:0] sum;
        sum = {1'b0, l} + {1'b0, h};
        return sum[W:1];
    endfunction

    rgb_flag_decode u_decode (
        .r_le (r_le),
        .g_ne (g_ne),
        .b_ge (b_ge),
        .res  (res)
    );

    assign guess_dec = guess - W'(1);
    assign guess_inc = guess + W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            lo     <= '0;
            hi     <= '1;
            guess  <= '0;
            found  <= '0;
            probes <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_next;
            lo     <= lo_next;
            hi     <= hi_next;
            guess  <= guess_next;
            found  <= found_next;
            probes <= probes_next;
            cnt    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        lo_next     = lo;
        hi_next     = hi;
        guess_next  = guess;
        found_next  = found;
        probes_next = probes;
        cnt_next    = cnt;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next  = WAIT;
                    lo_next     = '0;
                    hi_next     = '1;
                    guess_next  = midpoint('0, '1);
                    probes_next = '0;
                    cnt_next    = SETTLE_LOAD;
                end
            end

            WAIT: begin
                if (cnt == '0) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end

            SAMPLE: begin
                probes_next = probes + PW'(1);
                case (res)
                    EQ: begin
                        state_next = DONE;
                        found_next = guess;
                    end
                    HIGH: begin
                        // A HIGH answer at the bottom of the range means a is below lo.
                        if (guess == lo) begin
                            state_next = ERR;
                        end else begin
                            hi_next    = guess_dec;
                            guess_next = midpoint(lo, guess_dec);
                            cnt_next   = SETTLE_LOAD;
                            state_next = WAIT;
                        end
                    end
                    LOW: begin
                        if (guess == hi) begin
                            state_next = ERR;
                        end else begin
                            lo_next    = guess_inc;
                            guess_next = midpoint(guess_inc, hi);
                            cnt_next   = SETTLE_LOAD;
                            state_next = WAIT;
                        end
                    end
                    default: state_next = ERR;
                endcase
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == WAIT) || (state == SAMPLE);
    assign done = (state == DONE);
    assign err  = (state == ERR);

endmodule

// File: tb/tb_rgb_cmp_searcher.sv
// Directed bench for rgb_cmp_searcher: two instances (W=2/SETTLE=0 and
// W=4/SETTLE=2) each closed in a loop with a behavioural comparator.
module tb_rgb_cmp_searcher;

    logic clk;
    logic rst_n;

    // W=2, SETTLE=0 instance
    logic       start2;
    logic [1:0] secret2;
    logic       force2;
    logic [2:0] forced2;
    logic [2:0] flags2;
    logic [1:0] guess2;
    logic       busy2, done2, err2;
    logic [1:0] found2;
    logic [1:0] probes2;

    // W=4, SETTLE=2 instance
    logic       start4;
    logic [3:0] secret4;
    logic [2:0] flags4;
    logic [3:0] guess4;
    logic       busy4, done4, err4;
    logic [3:0] found4;
    logic [2:0] probes4;

    int total;
    int bad;
    int cyc;

    // Comparator behaviour: {a<=b, a!=b, a>=b}
    assign flags2 = force2 ? forced2
                           : {secret2 <= guess2, secret2 != guess2, secret2 >= guess2};
    assign flags4 = {secret4 <= guess4, secret4 != guess4, secret4 >= guess4};

    rgb_cmp_searcher #(.W(2), .SETTLE(0)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .r_le   (flags2[2]),
        .g_ne   (flags2[1]),
        .b_ge   (flags2[0]),
        .guess  (guess2),
        .busy   (busy2),
        .done   (done2),
        .found  (found2),
        .probes (probes2),
        .err    (err2)
    );

    rgb_cmp_searcher #(.W(4), .SETTLE(2)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .r_le   (flags4[2]),
        .g_ne   (flags4[1]),
        .b_ge   (flags4[0]),
        .guess  (guess4),
        .busy   (busy4),
        .done   (done4),
        .found  (found4),
        .probes (probes4),
        .err    (err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on one instance (sel=2 or 4); returns 1ns after the start edge.
    task automatic applyStimulus(input int sel);
        if (sel == 2) start2 = 1'b1;
        else          start4 = 1'b1;
        tick();
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic wait2(output int cycles);
        cycles = 0;
        while (!(done2 || err2) && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic wait4(output int cycles);
        cycles = 0;
        while (!(done4 || err4) && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    int exp_probes2 [4] = '{2, 1, 2, 3};

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start2  = 1'b0;
        start4  = 1'b0;
        secret2 = 2'd0;
        secret4 = 4'd0;
        force2  = 1'b0;
        forced2 = 3'b000;

        tick();
        tick();
        checkOutput("rst2_guess",  guess2,  0);
        checkOutput("rst2_found",  found2,  0);
        checkOutput("rst2_probes", probes2, 0);
        checkOutput("rst2_busy",   busy2,   0);
        checkOutput("rst2_done",   done2,   0);
        checkOutput("rst2_err",    err2,    0);
        checkOutput("rst4_guess",  guess4,  0);
        checkOutput("rst4_busy",   busy4,   0);
        rst_n = 1'b1;
        tick();

        // W=2 exhaustive sweep; every EQ probe costs two cycles
        for (int a = 0; a < 4; a++) begin
            secret2 = 2'(a);
            applyStimulus(2);
            checkOutput($sformatf("w2_a%0d_first_guess", a), guess2, 1);
            checkOutput($sformatf("w2_a%0d_busy", a), busy2, 1);
            wait2(cyc);
            checkOutput($sformatf("w2_a%0d_done", a), done2, 1);
            checkOutput($sformatf("w2_a%0d_err", a), err2, 0);
            checkOutput($sformatf("w2_a%0d_busy_low", a), busy2, 0);
            checkOutput($sformatf("w2_a%0d_found", a), found2, a);
            checkOutput($sformatf("w2_a%0d_probes", a), probes2, exp_probes2[a]);
            checkOutput($sformatf("w2_a%0d_cycles", a), cyc, 2 * exp_probes2[a]);
            tick();
        end

        // W=4 SETTLE=2 a=15: guesses 7,11,13,14,15 each held four cycles
        begin
            int exp_g [5] = '{7, 11, 13, 14, 15};
            secret4 = 4'd15;
            applyStimulus(4);
            for (int p = 0; p < 5; p++) begin
                checkOutput($sformatf("w4_guess_%0d", p), guess4, exp_g[p]);
                for (int k = 0; k < 4; k++) begin
                    if (p == 4 && k == 3) checkOutput("w4_not_done_at_19", done4, 0);
                    tick();
                end
            end
            checkOutput("w4_done_at_20", done4, 1);
            checkOutput("w4_found", found4, 15);
            checkOutput("w4_probes", probes4, 5);
            checkOutput("w4_busy_low", busy4, 0);
        end

        // Illegal 000 flags on the very first sample
        force2  = 1'b1;
        forced2 = 3'b000;
        applyStimulus(2);
        tick();
        tick();
        checkOutput("ill_err",    err2,    1);
        checkOutput("ill_busy",   busy2,   0);
        checkOutput("ill_done",   done2,   0);
        checkOutput("ill_guess",  guess2,  1);
        checkOutput("ill_probes", probes2, 1);
        tick();
        checkOutput("ill_guess_hold", guess2, 1);

        // Flags stuck at LOW: guesses climb 1,2,3 then error without wrapping
        forced2 = 3'b011;
        applyStimulus(2);
        checkOutput("low_err_cleared", err2, 0);
        checkOutput("low_guess_1", guess2, 1);
        tick();
        tick();
        checkOutput("low_guess_2", guess2, 2);
        tick();
        tick();
        checkOutput("low_guess_3", guess2, 3);
        tick();
        tick();
        checkOutput("low_err",    err2,    1);
        checkOutput("low_guess_hold", guess2, 3);
        checkOutput("low_probes", probes2, 3);
        checkOutput("low_done",   done2,   0);
        force2 = 1'b0;

        // Reset during the second WAIT of a W=4 search
        secret4 = 4'd9;
        applyStimulus(4);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("mid_guess_before_rst", guess4, 11);
        rst_n = 1'b0;
        tick();
        checkOutput("mid_rst_guess",  guess4,  0);
        checkOutput("mid_rst_found",  found4,  0);
        checkOutput("mid_rst_probes", probes4, 0);
        checkOutput("mid_rst_busy",   busy4,   0);
        checkOutput("mid_rst_done",   done4,   0);
        checkOutput("mid_rst_err",    err4,    0);
        rst_n = 1'b1;
        tick();
        checkOutput("mid_idle_busy", busy4, 0);
        applyStimulus(4);
        wait4(cyc);
        checkOutput("post_rst_done",   done4,   1);
        checkOutput("post_rst_found",  found4,  9);
        checkOutput("post_rst_probes", probes4, 3);
        checkOutput("post_rst_cycles", cyc, 12);

        // Start held high across the whole search must not restart it
        tick();
        secret4 = 4'd5;
        start4  = 1'b1;
        tick();
        checkOutput("hold_done_cleared", done4, 0);
        wait4(cyc);
        start4 = 1'b0;
        checkOutput("hold_done",   done4,   1);
        checkOutput("hold_found",  found4,  5);
        checkOutput("hold_probes", probes4, 3);
        checkOutput("hold_cycles", cyc, 12);
        tick();
        applyStimulus(4);
        checkOutput("re_done_cleared", done4, 0);
        checkOutput("re_busy", busy4, 1);
        wait4(cyc);
        checkOutput("re_done",   done4,   1);
        checkOutput("re_found",  found4,  5);
        checkOutput("re_probes", probes4, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
